freq_meter_autorange: RTL and testbench

//  Parametrised successor of the fixed 4-digit frequency tester. Counts rising edges of an async

---
 rtl/freq_meter_autorange.sv | 177 +++++++++++++++++
 tb/tb_freq_meter_autorange.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/freq_meter_autorange.sv
// Auto-ranging BCD frequency meter (macro FREQ_METER_LEADZERO_BLANK_EN blanks leading zeros).
// Latency: sig_in edge reaches counter after SYNC_STAGES+1 cycles; result each G+1 cycles. No backpressure.
module freq_meter_autorange #(
    parameter int CLK_HZ      = 50_000_000,
    parameter int NDIG        = 4,
    parameter int NRANGE      = 3,
    parameter int SYNC_STAGES = 2,
    localparam int RW         = (NRANGE > 1) ? $clog2(NRANGE) : 1
) (
    input  logic                sysclk,
    input  logic                resetb,
    input  logic                sig_in,
    input  logic                auto_en,
    input  logic [RW-1:0]       range_sel,
    output logic [4*NDIG-1:0]   bcd,
    output logic [RW-1:0]       range_out,
    output logic                overflow,
    output logic                meas_valid,
    output logic [7*NDIG-1:0]   seg
);
    localparam int            CW   = $clog2(CLK_HZ + 1);
    localparam logic [RW-1:0] RMAX = RW'(NRANGE - 1);

    typedef enum logic {S_GATE, S_EVAL} state_t;

    state_t                 state_q, state_nxt;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sig_prev_q;
    logic                   inc;
    logic [CW-1:0]          gate_cnt_q;
    logic                   gate_last;
    logic [4*NDIG-1:0]      cnt_q, cnt_inc;
    logic                   bcd_carry;
    logic                   ovf_q;
    logic [RW-1:0]          range_q, range_nxt, range_clamp;
    logic                   publish, pub_ovf, clear_cnt;
    logic [7*NDIG-1:0]      seg_nxt;
`ifdef FREQ_METER_LEADZERO_BLANK_EN
    logic                   lead;
`endif

    // Last gate-counter index per range, padded to a power of two so any range code is safe.
    logic [CW-1:0] gate_last_tbl [2**RW];
    for (genvar gi = 0; gi < 2**RW; gi++) begin : g_gate
        localparam int RI = (gi < NRANGE) ? gi : NRANGE - 1;
        assign gate_last_tbl[gi] = CW'(CLK_HZ / (10**RI) - 1);
    end

    assign inc         = sync_q[SYNC_STAGES-1] & ~sig_prev_q;
    assign gate_last   = (gate_cnt_q == gate_last_tbl[range_q]);
    assign range_clamp = (range_sel > RMAX) ? RMAX : range_sel;

    always_comb begin
        cnt_inc   = cnt_q;
        bcd_carry = 1'b1;
        for (int i = 0; i < NDIG; i++) begin
            if (bcd_carry) begin
                if (cnt_q[4*i +: 4] == 4'd9) begin
                    cnt_inc[4*i +: 4] = 4'd0;
                end else begin
                    cnt_inc[4*i +: 4] = cnt_q[4*i +: 4] + 4'd1;
                    bcd_carry         = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge sysclk or negedge resetb) begin
        if (!resetb) state_q <= S_GATE;
        else         state_q <= state_nxt;
    end

    always_comb begin
        state_nxt = state_q;
        publish   = 1'b0;
        pub_ovf   = 1'b0;
        clear_cnt = 1'b0;
        range_nxt = range_q;
        case (state_q)
            S_GATE: if (gate_last) state_nxt = S_EVAL;
            S_EVAL: begin
                state_nxt = S_GATE;
                clear_cnt = 1'b1;
                if (auto_en) begin
                    if (ovf_q) begin
                        if (range_q != RMAX) begin
                            range_nxt = range_q + RW'(1);
                        end else begin
                            publish = 1'b1;
                            pub_ovf = 1'b1;
                        end
                    end else begin
                        publish = 1'b1;
                        // Step down only when the top digit is unused: cannot bounce back up.
                        if (cnt_q[4*(NDIG-1) +: 4] == 4'd0 && range_q != '0)
                            range_nxt = range_q - RW'(1);
                    end
                end else begin
                    publish   = 1'b1;
                    pub_ovf   = ovf_q;
                    range_nxt = range_clamp;
                end
            end
            default: state_nxt = S_GATE;
        endcase
    end

    always_ff @(posedge sysclk or negedge resetb) begin
        if (!resetb) begin
            sync_q     <= '0;
            sig_prev_q <= 1'b0;
            gate_cnt_q <= '0;
            cnt_q      <= '0;
            ovf_q      <= 1'b0;
            range_q    <= '0;
            bcd        <= '0;
            range_out  <= '0;
            overflow   <= 1'b0;
            meas_valid <= 1'b0;
        end else begin
            sync_q     <= {sync_q[SYNC_STAGES-2:0], sig_in};
            sig_prev_q <= sync_q[SYNC_STAGES-1];
            range_q    <= range_nxt;
            meas_valid <= publish;
            if (clear_cnt) begin
                gate_cnt_q <= '0;
                cnt_q      <= '0;
                ovf_q      <= 1'b0;
            end else begin
                if (!gate_last) gate_cnt_q <= gate_cnt_q + CW'(1);
                if (inc) begin
                    cnt_q <= cnt_inc;
                    if (bcd_carry) ovf_q <= 1'b1;
                end
            end
            if (publish) begin
                bcd       <= pub_ovf ? {NDIG{4'h9}} : cnt_q;
                range_out <= range_q;
                overflow  <= pub_ovf;
            end
        end
    end

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'h3F;
            4'd1:    seg7 = 7'h06;
            4'd2:    seg7 = 7'h5B;
            4'd3:    seg7 = 7'h4F;
            4'd4:    seg7 = 7'h66;
            4'd5:    seg7 = 7'h6D;
            4'd6:    seg7 = 7'h7D;
            4'd7:    seg7 = 7'h07;
            4'd8:    seg7 = 7'h7F;
            4'd9:    seg7 = 7'h6F;
            default: seg7 = 7'h00;
        endcase
    endfunction

    always_comb begin
        seg_nxt = '0;
`ifdef FREQ_METER_LEADZERO_BLANK_EN
        lead = 1'b1;
        for (int i = NDIG - 1; i >= 0; i--) begin
            lead = lead && (bcd[4*i +: 4] == 4'd0) && (i != 0);
            seg_nxt[7*i +: 7] = lead ? 7'h00 : seg7(bcd[4*i +: 4]);
        end
`else
        for (int i = 0; i < NDIG; i++) seg_nxt[7*i +: 7] = seg7(bcd[4*i +: 4]);
`endif
    end

    always_ff @(posedge sysclk or negedge resetb) begin
        if (!resetb) seg <= {NDIG{7'h3F}};
        else         seg <= seg_nxt;
    end
endmodule

// File: tb/tb_freq_meter_autorange.sv
// Directed bench for freq_meter_autorange (CLK_HZ=1000, NDIG=2, NRANGE=3) with a result scoreboard.
module tb_freq_meter_autorange;
    logic        sysclk, resetb, sig_in, auto_en;
    logic [1:0]  range_sel, range_out;
    logic [7:0]  bcd;
    logic        overflow, meas_valid;
    logic [13:0] seg;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [1:0] rng;
        logic       ovf;
    } exp_t;

    exp_t sb[$];
    int   n_total = 0;
    int   n_bad   = 0;
    int   half    = 0;
    logic chk_en  = 1'b0;

    freq_meter_autorange #(.CLK_HZ(1000), .NDIG(2), .NRANGE(3), .SYNC_STAGES(2)) dut (
        .sysclk(sysclk), .resetb(resetb), .sig_in(sig_in), .auto_en(auto_en),
        .range_sel(range_sel), .bcd(bcd), .range_out(range_out), .overflow(overflow),
        .meas_valid(meas_valid), .seg(seg)
    );

    initial begin
        sysclk = 1'b0;
        forever #5 sysclk = ~sysclk;
    end

    // Toggle times stay at 2 mod 10 ns, away from both clock edges.
    initial begin
        sig_in = 1'b0;
        #2;
        forever begin
            if (half == 0) #10;
            else begin
                #(half);
                sig_in = ~sig_in;
            end
        end
    end

    always @(negedge sysclk) begin
        if (resetb && meas_valid && chk_en) begin
            if (sb.size() == 0) begin
                n_total++;
                n_bad++;
                $error("FAIL unexpected_meas bcd=%h range=%0d ovf=%0b", bcd, range_out, overflow);
            end else begin
                exp_t e;
                logic [7:0] want;
                e = sb.pop_front();
                want = (bcd === e.b) ? e.b : e.a;
                n_total += 3;
                assert (bcd === want) else begin
                    n_bad++;
                    $error("FAIL meas_bcd got=%h want=%h/%h", bcd, e.a, e.b);
                end
                assert (range_out === e.rng) else begin
                    n_bad++;
                    $error("FAIL meas_range got=%0d want=%0d", range_out, e.rng);
                end
                assert (overflow === e.ovf) else begin
                    n_bad++;
                    $error("FAIL meas_ovf got=%0b want=%0b", overflow, e.ovf);
                end
            end
        end
    end

    task automatic push_exp(input logic [7:0] a, input logic [7:0] b, input logic [1:0] rng,
                            input logic ovf);
        exp_t e;
        e.a = a; e.b = b; e.rng = rng; e.ovf = ovf;
        sb.push_back(e);
    endtask

    task automatic run_checks(input int budget);
        int c;
        c = 0;
        @(posedge sysclk);
        chk_en = 1'b1;
        while (sb.size() != 0 && c < budget) begin
            @(posedge sysclk);
            c++;
        end
        chk_en = 1'b0;
        n_total++;
        assert (sb.size() === 0) else begin
            n_bad++;
            $error("FAIL sb_drain pending=%0d want=0", sb.size());
            sb.delete();
        end
        @(negedge sysclk);
    endtask

    task automatic skip_meas(input int n, input int budget);
        int got, c;
        got = 0;
        c = 0;
        while (got < n && c < budget) begin
            @(posedge sysclk);
            c++;
            @(negedge sysclk);
            if (meas_valid) got++;
        end
        n_total++;
        assert (got === n) else begin
            n_bad++;
            $error("FAIL skip_meas got=%0d want=%0d", got, n);
        end
    endtask

    task automatic cycles_to_meas(input int limit, output int c);
        c = 0;
        while (c < limit) begin
            @(posedge sysclk);
            c++;
            @(negedge sysclk);
            if (meas_valid) break;
        end
    endtask

    task automatic check_seg(input string tag, input logic [13:0] want);
        n_total++;
        assert (seg === want) else begin
            n_bad++;
            $error("FAIL %s got=%h want=%h", tag, seg, want);
        end
    endtask

    initial begin
        int c;
        logic [13:0] seg05;
`ifdef FREQ_METER_LEADZERO_BLANK_EN
        seg05 = {7'h00, 7'h6D};
`else
        seg05 = {7'h3F, 7'h6D};
`endif
        resetb = 1'b0; auto_en = 1'b1; range_sel = 2'd0; half = 200;
        repeat (3) @(negedge sysclk);
        resetb = 1'b1;

        // 1: reset mid-gate while sig_in toggles, then exact first-result latency
        repeat (1500) @(negedge sysclk);
        resetb = 1'b0;
        repeat (3) @(negedge sysclk);
        n_total += 5;
        assert (bcd === 8'h00) else begin n_bad++; $error("FAIL rst_bcd got=%h want=00", bcd); end
        assert (range_out === 2'd0) else begin n_bad++; $error("FAIL rst_range got=%0d want=0", range_out); end
        assert (overflow === 1'b0) else begin n_bad++; $error("FAIL rst_ovf got=%0b want=0", overflow); end
        assert (meas_valid === 1'b0) else begin n_bad++; $error("FAIL rst_mv got=%0b want=0", meas_valid); end
        assert (seg === 14'h1FBF) else begin n_bad++; $error("FAIL rst_seg got=%h want=1fbf", seg); end
        resetb = 1'b1;
        cycles_to_meas(1200, c);
        n_total++;
        assert (c === 1001) else begin n_bad++; $error("FAIL first_latency got=%0d want=1001", c); end

        // 2: period 40 clk in auto mode
        repeat (3) push_exp(8'h25, 8'h25, 2'd0, 1'b0);
        run_checks(4000);
        check_seg("seg_25", {7'h5B, 7'h6D});
        skip_meas(1, 1200);
        cycles_to_meas(1200, c);
        n_total++;
        assert (c === 1001) else begin n_bad++; $error("FAIL meas_period got=%0d want=1001", c); end

        // 3: period 4 forces range 1; then period 400 steps back down to range 0
        half = 20;
        repeat (2) push_exp(8'h25, 8'h25, 2'd1, 1'b0);
        run_checks(2000);
        repeat (50) @(negedge sysclk);
        half = 2000;
        skip_meas(1, 300);
        push_exp(8'h00, 8'h01, 2'd1, 1'b0);
        repeat (2) push_exp(8'h02, 8'h03, 2'd0, 1'b0);
        run_checks(2500);

        // 4: manual range 0 with period 4 saturates
        auto_en = 1'b0; range_sel = 2'd0; half = 20;
        repeat (2) push_exp(8'h99, 8'h99, 2'd0, 1'b1);
        run_checks(2500);
        check_seg("seg_99", {7'h6F, 7'h6F});

        // 5: range_sel changed mid-gate only applies from the next gate; 3 clamps to 2
        repeat (500) @(negedge sysclk);
        range_sel = 2'd3;
        push_exp(8'h99, 8'h99, 2'd0, 1'b1);
        repeat (2) push_exp(8'h02, 8'h03, 2'd2, 1'b0);
        run_checks(1000);

        // 6: period 200 clk, auto mode steps 2 -> 1 -> 0 and settles at 05
        half = 1000;
        skip_meas(2, 100);
        auto_en = 1'b1;
        push_exp(8'h00, 8'h01, 2'd2, 1'b0);
        push_exp(8'h00, 8'h01, 2'd1, 1'b0);
        repeat (2) push_exp(8'h05, 8'h05, 2'd0, 1'b0);
        run_checks(2500);
        @(negedge sysclk);
        check_seg("seg_05", seg05);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
